// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the 32-bit ALU and the execute-stage pipeline
//   wrapper around it.
//   - ALU control codes carried on aluc.
//   - Default datapath and register-number widths.
//   - Forwarding-source encoding plus the priority helper used by fwd_mux.
package alu_pkg;

    localparam int ALU_DW = 32;  // datapath width, must match the ALU
    localparam int ALU_RW = 5;   // register-number width

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_LUI = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1111;

    // Where an issued operand comes from.
    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,  // register-file value from decode
        FWD_EX   = 2'd1,  // ALU result of the operation now in EX
        FWD_WB   = 2'd2   // result latched in the WB register
    } fwd_sel_e;

    // EX is younger than WB, so an EX hit always wins.
    function automatic fwd_sel_e fwd_pick(input logic ex_hit, input logic wb_hit);
        if (ex_hit) begin
            return FWD_EX;
        end
        if (wb_hit) begin
            return FWD_WB;
        end
        return FWD_NONE;
    endfunction

endpackage

// File: rtl/alu_ex_pipe_fwd_mux.sv
// fwd_mux
//   Three-way forwarding select for one source operand.
//   Ports:
//     en        operand may be forwarded (low for immediates)
//     src       source register number of the operand
//     rf_val    register-file value supplied by decode
//     ex_valid, ex_wreg, ex_rd, ex_val   operation in EX and its live ALU result
//     wb_valid, wb_wreg, wb_rd, wb_val   operation in WB and its latched result
//     val       selected operand value
module fwd_mux
    import alu_pkg::*;
#(
    parameter int DW = ALU_DW,
    parameter int RW = ALU_RW
) (
    input  logic          en,
    input  logic [RW-1:0] src,
    input  logic [DW-1:0] rf_val,
    input  logic          ex_valid,
    input  logic          ex_wreg,
    input  logic [RW-1:0] ex_rd,
    input  logic [DW-1:0] ex_val,
    input  logic          wb_valid,
    input  logic          wb_wreg,
    input  logic [RW-1:0] wb_rd,
    input  logic [DW-1:0] wb_val,
    output logic [DW-1:0] val
);

    logic     ex_hit;
    logic     wb_hit;
    fwd_sel_e sel;

    // Register 0 is hard-wired, so a write to it never produces a match.
    always_comb begin
        ex_hit = en & ex_valid & ex_wreg & (ex_rd != '0) & (ex_rd == src);
        wb_hit = en & wb_valid & wb_wreg & (wb_rd != '0) & (wb_rd == src);
        sel    = fwd_pick(ex_hit, wb_hit);
    end

    always_comb begin
        val = rf_val;
        case (sel)
            FWD_EX:  val = ex_val;
            FWD_WB:  val = wb_val;
            default: val = rf_val;
        endcase
    end

endmodule

// File: rtl/alu_ex_pipe.sv
// alu_ex_pipe
//   Execute-stage pipeline wrapper around the 32-bit ALU. Two registers deep:
//   EX drives the ALU inputs, WB captures the ALU result. Results still in
//   flight in EX or WB are forwarded onto newly issued operands, so dependent
//   operations issue back to back without stalling. Older results have already
//   been written (write-through) into the register file by the time decode
//   reads them.
//
//   Handshakes: a transfer happens on a rising edge where valid and ready are
//   both high. ready never depends on valid. Decode -> EX uses d_valid/d_ready;
//   WB -> write-back uses w_valid/w_ready.
//
//   Ports:
//     clk, clrn                 clock, asynchronous active-low reset
//     d_valid, d_ready          decode handshake
//     d_aluc, d_a, d_b          ALU control and register-file operand values
//     d_rs, d_rt, d_bimm        source registers; d_bimm marks b as immediate
//     d_rd, d_wreg              destination register and its write enable
//     flush                     kill the operation held in EX
//     e_a, e_b, e_aluc          to the ALU (meaningful only while EX is valid)
//     alu_r, alu_z              from the ALU
//     w_valid, w_ready          write-back handshake
//     w_r, w_z, w_rd, w_wreg    latched result, zero flag, destination, enable
module alu_ex_pipe
    import alu_pkg::*;
#(
    parameter int DW = ALU_DW,
    parameter int RW = ALU_RW
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          d_valid,
    output logic          d_ready,
    input  logic [3:0]    d_aluc,
    input  logic [DW-1:0] d_a,
    input  logic [DW-1:0] d_b,
    input  logic [RW-1:0] d_rs,
    input  logic [RW-1:0] d_rt,
    input  logic          d_bimm,
    input  logic [RW-1:0] d_rd,
    input  logic          d_wreg,
    input  logic          flush,
    output logic [DW-1:0] e_a,
    output logic [DW-1:0] e_b,
    output logic [3:0]    e_aluc,
    input  logic [DW-1:0] alu_r,
    input  logic          alu_z,
    output logic          w_valid,
    input  logic          w_ready,
    output logic [DW-1:0] w_r,
    output logic          w_z,
    output logic [RW-1:0] w_rd,
    output logic          w_wreg
);

    logic          e_valid;
    logic [RW-1:0] e_rd;
    logic          e_wreg;

    logic          w_adv;    // WB is empty or being handed off this cycle
    logic          e_fire;   // EX operation moves into WB this cycle
    logic          accept;   // decode operation loads into EX this cycle
    logic [DW-1:0] fwd_a;
    logic [DW-1:0] fwd_b;

    // d_ready deliberately ignores flush: a flushed EX slot would free up
    // anyway, and keeping flush out avoids a path from flush to decode.
    // A flushed operation must not reach WB, so flush gates e_fire.
    always_comb begin
        w_adv   = ~w_valid | w_ready;
        e_fire  = e_valid & ~flush & w_adv;
        d_ready = ~e_valid | w_adv;
        accept  = d_valid & d_ready;
    end

    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_a (
        .en       (1'b1),
        .src      (d_rs),
        .rf_val   (d_a),
        .ex_valid (e_valid),
        .ex_wreg  (e_wreg),
        .ex_rd    (e_rd),
        .ex_val   (alu_r),
        .wb_valid (w_valid),
        .wb_wreg  (w_wreg),
        .wb_rd    (w_rd),
        .wb_val   (w_r),
        .val      (fwd_a)
    );

    // An immediate in b must pass through untouched even if d_rt happens
    // to name a register that is in flight.
    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_b (
        .en       (~d_bimm),
        .src      (d_rt),
        .rf_val   (d_b),
        .ex_valid (e_valid),
        .ex_wreg  (e_wreg),
        .ex_rd    (e_rd),
        .ex_val   (alu_r),
        .wb_valid (w_valid),
        .wb_wreg  (w_wreg),
        .wb_rd    (w_rd),
        .wb_val   (w_r),
        .val      (fwd_b)
    );

    // EX register. Data fields only change on accept, which keeps the ALU
    // inputs (and so alu_r) stable for the whole of a stall.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            e_valid <= 1'b0;
            e_a     <= '0;
            e_b     <= '0;
            e_aluc  <= '0;
            e_rd    <= '0;
            e_wreg  <= 1'b0;
        end else begin
            if (accept) begin
                // A same-cycle flush targets the older operation leaving EX;
                // the newly accepted one still loads.
                e_valid <= 1'b1;
                e_a     <= fwd_a;
                e_b     <= fwd_b;
                e_aluc  <= d_aluc;
                e_rd    <= d_rd;
                e_wreg  <= d_wreg;
            end else if (flush || e_fire) begin
                e_valid <= 1'b0;
            end
        end
    end

    // WB register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            w_valid <= 1'b0;
            w_r     <= '0;
            w_z     <= 1'b0;
            w_rd    <= '0;
            w_wreg  <= 1'b0;
        end else begin
            if (e_fire) begin
                w_valid <= 1'b1;
                w_r     <= alu_r;
                w_z     <= alu_z;
                w_rd    <= e_rd;
                w_wreg  <= e_wreg;
            end else if (w_ready) begin
                w_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_ex_pipe.sv
// tb_alu_ex_pipe
//   Bench for alu_ex_pipe. An ALU stub closes the loop from e_* to alu_r/alu_z.
//   The reference model is architectural: every accepted operation is
//   evaluated in program order against a register array that is updated at
//   accept, and the expected {r, z, rd, wreg} is queued for the WB handshake.
//   A second array models the real register file (written at the WB handshake,
//   write-through) and supplies d_a/d_b to the DUT.
module tb_alu_ex_pipe;
    import alu_pkg::*;

    localparam int EW = 39;  // {r[31:0], z, rd[4:0], wreg}

    logic        clk;
    logic        clrn;
    logic        d_valid;
    logic        d_ready;
    logic [3:0]  d_aluc;
    logic [31:0] d_a;
    logic [31:0] d_b;
    logic [4:0]  d_rs;
    logic [4:0]  d_rt;
    logic        d_bimm;
    logic [4:0]  d_rd;
    logic        d_wreg;
    logic        flush;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic [3:0]  e_aluc;
    logic [31:0] alu_r;
    logic        alu_z;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_r;
    logic        w_z;
    logic [4:0]  w_rd;
    logic        w_wreg;

    logic [EW-1:0] exp_q[$];
    logic [31:0]   rf[32];    // register file seen by decode
    logic [31:0]   arch[32];  // architectural state after all accepted ops
    logic [3:0]    codes[9];
    int            n_checks;
    int            n_errors;

    alu_ex_pipe #(.DW(32), .RW(5)) dut (
        .clk     (clk),
        .clrn    (clrn),
        .d_valid (d_valid),
        .d_ready (d_ready),
        .d_aluc  (d_aluc),
        .d_a     (d_a),
        .d_b     (d_b),
        .d_rs    (d_rs),
        .d_rt    (d_rt),
        .d_bimm  (d_bimm),
        .d_rd    (d_rd),
        .d_wreg  (d_wreg),
        .flush   (flush),
        .e_a     (e_a),
        .e_b     (e_b),
        .e_aluc  (e_aluc),
        .alu_r   (alu_r),
        .alu_z   (alu_z),
        .w_valid (w_valid),
        .w_ready (w_ready),
        .w_r     (w_r),
        .w_z     (w_z),
        .w_rd    (w_rd),
        .w_wreg  (w_wreg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    // ---------------- ALU behaviour ----------------
    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] c);
        case (c)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            ALU_LUI: return {b[15:0], 16'h0000};
            ALU_SLL: return b << a[4:0];
            ALU_SRL: return b >> a[4:0];
            ALU_SRA: return $unsigned($signed(b) >>> a[4:0]);
            default: return a + b;
        endcase
    endfunction

    always_comb begin
        alu_r = alu_f(e_a, e_b, e_aluc);
        alu_z = (alu_r == 32'd0);
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Register-file read with write-through of the result committing this cycle.
    function automatic logic [31:0] rf_rd(input logic [4:0] idx, input logic hs,
                                          input logic [EW-1:0] f);
        if (idx == 5'd0) return 32'd0;
        if (hs && f[0] && f[5:1] == idx) return f[38:7];
        return rf[idx];
    endfunction

    // ---------------- driver ----------------
    // Entered just after a falling edge; drives one cycle, scores the WB
    // handshake, models an accept, and returns just after the next falling edge.
    task automatic cycle(input logic v, input logic [3:0] c, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic wreg,
                         input logic bimm, input logic [31:0] imm, input logic wr,
                         input logic fl, input logic drop, output logic acc);
        logic [EW-1:0] f;
        logic          hs;
        logic [31:0]   oa;
        logic [31:0]   ob;
        logic [31:0]   r;
        w_ready = wr;
        flush   = fl;
        hs      = w_valid & wr;
        f       = (exp_q.size() > 0) ? exp_q[0] : '0;
        d_valid = v;
        d_aluc  = c;
        d_rs    = rs;
        d_rt    = rt;
        d_rd    = rd;
        d_wreg  = wreg;
        d_bimm  = bimm;
        d_a     = rf_rd(rs, hs, f);
        d_b     = bimm ? imm : rf_rd(rt, hs, f);
        #1;
        if (w_valid && w_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_wb", {31'd0, w_valid}, 32'd0);
            end else begin
                f = exp_q.pop_front();
                check("w_r", w_r, f[38:7]);
                check("w_z", {31'd0, w_z}, {31'd0, f[6]});
                check("w_rd", {27'd0, w_rd}, {27'd0, f[5:1]});
                check("w_wreg", {31'd0, w_wreg}, {31'd0, f[0]});
                if (f[0] && f[5:1] != 5'd0) rf[f[5:1]] = f[38:7];
            end
        end
        if (drop) begin
            if (exp_q.size() > 0) void'(exp_q.pop_back());
        end
        acc = d_valid & d_ready;
        if (acc) begin
            oa = (rs == 5'd0) ? 32'd0 : arch[rs];
            ob = bimm ? imm : ((rt == 5'd0) ? 32'd0 : arch[rt]);
            r  = alu_f(oa, ob, c);
            exp_q.push_back({r, (r == 32'd0), rd, wreg});
            if (wreg && rd != 5'd0) arch[rd] = r;
        end
        @(posedge clk);
        @(negedge clk);
        d_valid = 1'b0;
        flush   = 1'b0;
    endtask

    task automatic op(input logic [3:0] c, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic wreg, input logic bimm,
                      input logic [31:0] imm, input logic wr);
        logic acc;
        cycle(1'b1, c, rs, rt, rd, wreg, bimm, imm, wr, 1'b0, 1'b0, acc);
    endtask

    task automatic idle(input logic wr);
        logic acc;
        cycle(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, wr, 1'b0, 1'b0, acc);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            idle(1'b1);
            n++;
        end
        idle(1'b1);
        check("drain_left", exp_q.size(), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_w_valid"}, {31'd0, w_valid}, 32'd0);
        check({tag, "_w_r"}, w_r, 32'd0);
        check({tag, "_w_z"}, {31'd0, w_z}, 32'd0);
        check({tag, "_w_rd"}, {27'd0, w_rd}, 32'd0);
        check({tag, "_w_wreg"}, {31'd0, w_wreg}, 32'd0);
        check({tag, "_e_a"}, e_a, 32'd0);
        check({tag, "_e_b"}, e_b, 32'd0);
        check({tag, "_e_aluc"}, {28'd0, e_aluc}, 32'd0);
        check({tag, "_d_ready"}, {31'd0, d_ready}, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic        acc;
        logic        pend;
        logic [3:0]  pc;
        logic [4:0]  prs;
        logic [4:0]  prt;
        logic [4:0]  prd;
        logic        pw;
        logic        pb;
        logic [31:0] pimm;

        n_checks = 0;
        n_errors = 0;
        codes[0] = ALU_ADD; codes[1] = ALU_SUB; codes[2] = ALU_AND;
        codes[3] = ALU_OR;  codes[4] = ALU_XOR; codes[5] = ALU_LUI;
        codes[6] = ALU_SLL; codes[7] = ALU_SRL; codes[8] = ALU_SRA;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        rf[1] = 32'd5; rf[2] = 32'd7; rf[6] = 32'd9; rf[7] = 32'd4;
        rf[16] = 32'd1; rf[17] = 32'd2;
        for (int i = 0; i < 32; i++) arch[i] = rf[i];

        clrn = 1'b0; d_valid = 1'b0; d_aluc = 4'd0; d_a = 32'd0; d_b = 32'd0;
        d_rs = 5'd0; d_rt = 5'd0; d_bimm = 1'b0; d_rd = 5'd0; d_wreg = 1'b0;
        flush = 1'b0; w_ready = 1'b1;
        @(negedge clk);
        check_reset_state("rst");
        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);

        // Basic add then sub to zero, checking the 2-deep latency.
        op(ALU_ADD, 5'd1, 5'd2, 5'd20, 1'b1, 1'b0, 32'd0, 1'b1);
        check("lat_wv0", {31'd0, w_valid}, 32'd0);
        op(ALU_SUB, 5'd6, 5'd6, 5'd21, 1'b1, 1'b0, 32'd0, 1'b1);
        check("add_wv", {31'd0, w_valid}, 32'd1);
        check("add_r", w_r, 32'd12);
        check("add_z", {31'd0, w_z}, 32'd0);
        idle(1'b1);
        check("sub_r", w_r, 32'd0);
        check("sub_z", {31'd0, w_z}, 32'd1);
        drain();

        // RAW chain: r3 = 1+2, r4 = r3 & 6, r5 = r3 ^ r4.
        op(ALU_ADD, 5'd16, 5'd17, 5'd3, 1'b1, 1'b0, 32'd0, 1'b1);
        op(ALU_AND, 5'd3, 5'd0, 5'd4, 1'b1, 1'b1, 32'd6, 1'b1);
        check("raw1_e_a", e_a, 32'd3);
        op(ALU_XOR, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 32'd0, 1'b1);
        check("raw2_e_a", e_a, 32'd3);
        check("raw2_e_b", e_b, 32'd2);
        check("raw_and_r", w_r, 32'd2);
        idle(1'b1);
        check("raw_xor_r", w_r, 32'd1);
        drain();

        // Register 0 is never forwarded.
        op(ALU_ADD, 5'd7, 5'd7, 5'd0, 1'b1, 1'b0, 32'd0, 1'b1);
        op(ALU_ADD, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 32'd1, 1'b1);
        check("r0_e_a", e_a, 32'd0);
        idle(1'b1);
        check("r0_r", w_r, 32'd1);
        drain();

        // Immediate guard: d_rt names the EX destination, b must stay immediate.
        op(ALU_ADD, 5'd1, 5'd2, 5'd10, 1'b1, 1'b0, 32'd0, 1'b1);
        op(ALU_OR, 5'd1, 5'd10, 5'd11, 1'b1, 1'b1, 32'h40, 1'b1);
        check("imm_e_b", e_b, 32'h40);
        drain();

        // Back-pressure: fill both stages, verify stall and stable ALU inputs.
        op(ALU_ADD, 5'd1, 5'd2, 5'd12, 1'b1, 1'b0, 32'd0, 1'b0);
        op(ALU_SUB, 5'd12, 5'd1, 5'd13, 1'b1, 1'b0, 32'd0, 1'b0);
        check("bp_d_ready", {31'd0, d_ready}, 32'd0);
        check("bp_e_a", e_a, 32'd12);
        check("bp_e_b", e_b, 32'd5);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, ALU_AND, 5'd13, 5'd12, 5'd18, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, acc);
            check("bp_held_acc", {31'd0, acc}, 32'd0);
            check("bp_hold_e_a", e_a, 32'd12);
            check("bp_hold_e_b", e_b, 32'd5);
        end
        cycle(1'b1, ALU_AND, 5'd13, 5'd12, 5'd18, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, acc);
        check("bp_accept", {31'd0, acc}, 32'd1);
        check("bp_fwd_a", e_a, 32'd7);
        check("bp_fwd_b", e_b, 32'd12);
        drain();

        // Flush with a same-cycle accept: X is dropped, Y survives.
        op(ALU_ADD, 5'd1, 5'd2, 5'd14, 1'b0, 1'b0, 32'd0, 1'b1);
        cycle(1'b1, ALU_SUB, 5'd2, 5'd1, 5'd15, 1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, acc);
        check("fl_accept", {31'd0, acc}, 32'd1);
        check("fl_wb_empty", {31'd0, w_valid}, 32'd0);
        check("fl_new_e_a", e_a, 32'd7);
        idle(1'b1);
        check("fl_new_r", w_r, 32'd2);
        drain();

        // Reset in the middle of a stall.
        op(ALU_ADD, 5'd1, 5'd2, 5'd22, 1'b1, 1'b0, 32'd0, 1'b0);
        op(ALU_XOR, 5'd22, 5'd6, 5'd23, 1'b1, 1'b0, 32'd0, 1'b0);
        clrn = 1'b0;
        #1;
        check_reset_state("mid");
        @(posedge clk);
        @(negedge clk);
        check("mid_hold_d_ready", {31'd0, d_ready}, 32'd1);
        clrn = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 32; i++) arch[i] = rf[i];
        idle(1'b1);
        check("mid_after_wv", {31'd0, w_valid}, 32'd0);

        // Randomized traffic with dependencies and random back-pressure.
        for (int i = 1; i < 32; i++) begin
            rf[i]   = $urandom;
            arch[i] = rf[i];
        end
        pend = 1'b0;
        pc = 4'd0; prs = 5'd0; prt = 5'd0; prd = 5'd0; pw = 1'b0; pb = 1'b0; pimm = 32'd0;
        for (int i = 0; i < 400; i++) begin
            if (!pend && $urandom_range(0, 3) != 0) begin
                pend = 1'b1;
                pc   = codes[$urandom_range(0, 8)];
                prs  = 5'($urandom_range(0, 7));
                prt  = 5'($urandom_range(0, 7));
                prd  = 5'($urandom_range(0, 7));
                pw   = ($urandom_range(0, 4) != 0);
                pb   = ($urandom_range(0, 3) == 0);
                pimm = $urandom;
            end
            cycle(pend, pc, prs, prt, prd, pw, pb, pimm, ($urandom_range(0, 3) != 0),
                  1'b0, 1'b0, acc);
            if (acc) pend = 1'b0;
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
